// File: rtl/mp_pkg.sv
// ---------------------------------------------------------------------------
// mp_pkg -- shared definitions for the multi-precision add/sub sequencer.
//   state_t : FSM state encoding (IDLE, FETCH, EXEC, DONE)
//   OP_ADD  : op_sub value selecting A+B
//   OP_SUB  : op_sub value selecting A-B
// ---------------------------------------------------------------------------
package mp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mp_addsub_seq_adder.sv
// ---------------------------------------------------------------------------
// adder -- one N-bit word add with carry in and carry out.
//   a, b : N-bit addends (b already inverted by the caller for subtraction)
//   cin  : carry into bit 0
//   s    : N-bit sum, wraps modulo 2^N
//   cout : carry out of bit N-1
// ---------------------------------------------------------------------------
module adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub_seq.sv
// ---------------------------------------------------------------------------
// mp_addsub_seq -- word-serial multi-precision adder/subtractor.
// Walks len operand words least-significant first, one word every two
// cycles (FETCH reads the operands, EXEC adds and writes the result word),
// chaining the carry between words.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request an operation (only looked at in IDLE)
//   op_sub            : 0 = A+B, 1 = A-B (latched on start)
//   len               : length in words, clamped to MAX_WORDS (latched)
//   rd_en, rd_addr    : operand read strobe and word index
//   a_word, b_word    : operand words returned by the memory
//   wr_en, wr_addr,
//   wr_data           : result word write port
//   busy              : operation in progress (FETCH/EXEC)
//   done              : one-cycle completion pulse
//   carry_out         : final carry (for A-B: 1 = no borrow, A>=B)
//   res_zero          : every written word was zero (MPAS_ZERO_FLAG_EN only)
//   dbg_state         : current FSM state, for observation only
//
// Handshake: rd_en is a one-cycle request with no back-pressure; the
// memory must present a_word/b_word on the cycle immediately after rd_en
// (that cycle is always EXEC). wr_en/done are one-cycle strobes with no
// ready; the consumer must accept them when they appear. All strobes and
// their address/data are driven to 0 while inactive.
//
// Optional build macro: MPAS_ZERO_FLAG_EN adds the res_zero output.
// ---------------------------------------------------------------------------
module mp_addsub_seq
  import mp_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 32,
  localparam int ADDR_W   = $clog2(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_sub,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              carry_out,
`ifdef MPAS_ZERO_FLAG_EN
  output logic              res_zero,
`endif
  output state_t            dbg_state
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_WORDS);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   index;
  logic [ADDR_W:0]     len_q;
  logic                op_q;
  logic                carry;
  logic                accept;
  logic                last_word;
  logic [WORD_W-1:0]   b_in;
  logic [WORD_W-1:0]   sum;
  logic                sum_c;

  assign accept    = (state == ST_IDLE) && start;
  assign last_word = ({1'b0, index} == (len_q - (ADDR_W + 1)'(1)));
  assign dbg_state = state;

  // Subtraction is A + ~B + 1; the +1 comes from carry being seeded with
  // op_sub on start.
  assign b_in = (op_q == OP_SUB) ? ~b_word : b_word;

  adder #(.N(WORD_W)) u_adder (
    .a    (a_word),
    .b    (b_in),
    .cin  (carry),
    .s    (sum),
    .cout (sum_c)
  );

  // -- FSM: state register --------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // -- FSM: next-state logic ------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = last_word ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // -- FSM: outputs ---------------------------------------------------------
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = index;
        busy    = 1'b1;
      end
      ST_EXEC: begin
        wr_en   = 1'b1;
        wr_addr = index;
        wr_data = sum;
        busy    = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // -- Datapath registers ---------------------------------------------------
  // carry_out is loaded on the edge entering DONE so it is already valid
  // while done is high, and then held until a later operation finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= '0;
      len_q     <= '0;
      op_q      <= 1'b0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op_sub;
        len_q <= (len > MAX_LEN) ? MAX_LEN : len;
        index <= '0;
        carry <= op_sub;
        if (len == '0) carry_out <= op_sub;
      end else if (state == ST_EXEC) begin
        carry <= sum_c;
        index <= index + ADDR_W'(1);
        if (last_word) carry_out <= sum_c;
      end
    end
  end

`ifdef MPAS_ZERO_FLAG_EN
  // zero_acc tracks "all words so far were zero"; an empty operation
  // writes nothing and so reports zero.
  logic zero_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc <= 1'b0;
      res_zero <= 1'b0;
    end else begin
      if (accept) begin
        zero_acc <= 1'b1;
        if (len == '0) res_zero <= 1'b1;
      end else if (state == ST_EXEC) begin
        zero_acc <= zero_acc & (sum == '0);
        if (last_word) res_zero <= zero_acc & (sum == '0);
      end
    end
  end
`endif

endmodule
